gray_ptr_sync: RTL and testbench
================================

# gray_ptr_sync

Receives a Gray-coded value from the Gray-code counter / binary-to-Gray stage, which runs in another clock domain or is otherwise asynchronous to this clock. It synchronizes that value into the local clock domain and converts it back to binary. It also reports per-sample change, the binary step size and illegal multi-bit Gray transitions. It sits directly downstream of the binary-to-Gray converter, as the read side of a Gray-coded pointer or counter crossing.

## Interface
Parameters:
- N, 4, width of the Gray and binary values
- SYNC_STAGES, 2, synchronizer depth; legal values ≥ 2

Ports:
- clk  input  1  local clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- gray_in  input  N  Gray-coded value, asynchronous to clk
- clr_err  input  1  synchronous clear of step_err and err_cnt
- gray_sync  output  N  last synchronizer stage
- bin_out  output  N  registered Gray-to-binary of gray_sync
- primed  output  1  high once comparisons are valid after reset
- change  output  1  one-cycle pulse when the synchronized value changed
- delta  output  N  (bin(new) − bin(prev)) mod 2^N, registered; 0 when no change
- step_err  output  1  sticky flag for an illegal transition (Hamming distance > 1)
- err_cnt  output  8  count of illegal transitions, saturating at 255

## Operation
- The synchronizer is a chain of SYNC_STAGES flops: s[0] ← gray_in, s[k] ← s[k-1]. gray_sync = s[SYNC_STAGES-1].
- The chain carries no logic, and nothing reads gray_in other than s[0].
- prev_gray ← gray_sync every cycle. prev_gray is internal.
- Gray-to-binary conversion: b[N-1] = g[N-1]; b[i] = b[i+1] ^ g[i].
- bin_out ← g2b(gray_sync) every cycle. bin_out is never masked.
- Warm-up counter: counts edges after reset release and stops at SYNC_STAGES+1. primed = (counter == SYNC_STAGES+1).
- Each edge with primed = 1, evaluated on pre-edge values:
  - diff = gray_sync ^ prev_gray.
  - change ← |diff.
  - delta ← change ? g2b(gray_sync) − g2b(prev_gray), truncated to N bits : 0.
  - A transition is illegal when popcount(diff) ≥ 2.
  - On an illegal transition: step_err ← 1 and err_cnt ← min(err_cnt+1, 255).
- While primed = 0: change and delta are forced to 0, and step_err and err_cnt hold.
- clr_err = 1 with no illegal transition: step_err ← 0, err_cnt ← 0.
- clr_err = 1 coincident with an illegal transition: set wins over clear, giving step_err = 1 and err_cnt = 1.
- Wrap-around (e.g. N=4, bin 15 → 0, Gray 1000 → 0000) is a legal single-bit transition with delta = 1.
- A backward step gives delta = 2^N − 1.
- Reset: rst_n low asynchronously clears all flops. Every output reads 0, including primed, gray_sync, bin_out, delta and err_cnt.
- Reset mid-operation: outputs go to 0 immediately. After release the warm-up counter restarts from 0, so the first comparison cannot flag a spurious error against the reset value.

## Timing
- gray_in → gray_sync: SYNC_STAGES edges after the first edge that samples the new value.
- gray_sync → bin_out, change, delta, step_err, err_cnt: +1 edge.
- Total latency gray_in → bin_out/change: SYNC_STAGES+1 edges (3 with default parameters).
- primed rises at edge SYNC_STAGES+1 after rst_n deasserts (edge 3 by default). The first compared value pair appears on outputs at edge SYNC_STAGES+2.
- change is high for exactly one cycle per distinct synchronized value. A constant gray_in gives change = 0.
- A new gray_in value every cycle yields a change pulse every cycle, with no loss.
- clr_err acts on the next edge. Its effect is visible one cycle later.

## Test plan
- Reset, N=4, SYNC_STAGES=2: hold rst_n low, gray_in = 0101 → all outputs 0. Release rst_n → primed = 1 after edge 3; change stays 0 and step_err = 0 through warm-up.
- Primed, gray_in 0000 → 0001: 2 edges later gray_sync = 0001; 1 edge after that bin_out = 1, change pulses for 1 cycle, delta = 1, step_err = 0.
- Wrap and reverse: drive 1000 (bin 15) then 0000 → delta = 1, no error. Then drive 0000 → 0001 → 0000 → final delta = 15.
- Illegal jump 0000 → 0011 → step_err = 1, err_cnt = 1, delta = 2. Second illegal jump → err_cnt = 2. clr_err for one cycle → step_err = 0, err_cnt = 0. clr_err coincident with an illegal jump → step_err = 1, err_cnt = 1.
- Saturation: 300 alternating illegal jumps (0000 ↔ 0011, each held 4 cycles) → err_cnt stops at 255 and step_err = 1.
- Reset mid-stream: assert rst_n low between clock edges while gray_in is incrementing → all outputs 0 before the next edge. After release, primed takes 3 edges and no spurious step_err or change appears.

Source files
------------

// File: rtl/gray_ptr_sync.sv
// Read side of a Gray-coded pointer crossing: synchronizes an asynchronous Gray
// value, converts it to binary and reports change, step size and illegal jumps.
module gray_ptr_sync #(
  parameter int N           = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] gray_in,
  input  logic         clr_err,
  output logic [N-1:0] gray_sync,
  output logic [N-1:0] bin_out,
  output logic         primed,
  output logic         change,
  output logic [N-1:0] delta,
  output logic         step_err,
  output logic [7:0]   err_cnt
);

  localparam int            CW   = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] WARM = CW'(SYNC_STAGES + 1);

  function automatic logic [N-1:0] g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  logic [N-1:0]  sync_p0 [SYNC_STAGES];
  logic [N-1:0]  prev_gray_p1;
  logic [CW-1:0] warm_cnt;
  logic [N-1:0]  diff;
  logic          illegal;

  assign gray_sync = sync_p0[SYNC_STAGES-1];
  assign primed    = (warm_cnt == WARM);
  assign diff      = gray_sync ^ prev_gray_p1;
  // More than one set bit in diff means the Gray code skipped a value.
  assign illegal   = primed && ((diff & (diff - N'(1))) != '0);

  // Stage p0: plain flop chain, nothing but s[0] touches gray_in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= gray_in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  // Warm-up: comparisons start only once prev_gray holds a synchronized value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_cnt <= '0;
    end else if (warm_cnt != WARM) begin
      warm_cnt <= warm_cnt + CW'(1);
    end
  end

  // Stage p1: binary conversion, change detection and error tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_gray_p1 <= '0;
      bin_out      <= '0;
      change       <= 1'b0;
      delta        <= '0;
      step_err     <= 1'b0;
      err_cnt      <= '0;
    end else begin
      prev_gray_p1 <= gray_sync;
      bin_out      <= g2b(gray_sync);
      if (primed) begin
        change <= |diff;
        delta  <= (|diff) ? g2b(gray_sync) - g2b(prev_gray_p1) : '0;
      end else begin
        change <= 1'b0;
        delta  <= '0;
      end
      if (illegal) begin
        step_err <= 1'b1;
        err_cnt  <= clr_err ? 8'd1 : sat_inc(err_cnt);
      end else if (clr_err) begin
        step_err <= 1'b0;
        err_cnt  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync (N=4, SYNC_STAGES=2) with a due-cycle scoreboard.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clr_err;
  logic [3:0] gray_sync;
  logic [3:0] bin_out;
  logic       primed;
  logic       change;
  logic [3:0] delta;
  logic       step_err;
  logic [7:0] err_cnt;

  gray_ptr_sync #(.N(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .clr_err(clr_err),
    .gray_sync(gray_sync), .bin_out(bin_out), .primed(primed), .change(change),
    .delta(delta), .step_err(step_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  function automatic logic [18:0] obs();
    return {primed, bin_out, change, delta, step_err, err_cnt};
  endfunction

  function automatic logic [22:0] obs_all();
    return {gray_sync, primed, bin_out, change, delta, step_err, err_cnt};
  endfunction

  task automatic push(input int d, input string tag, input logic prm, input logic [3:0] bin,
                      input logic chg, input logic [3:0] dlt, input logic err, input logic [7:0] cnt);
    exp_t e;
    e.due = cyc + d;
    e.tag = tag;
    e.v   = {prm, bin, chg, dlt, err, cnt};
    sb.push_back(e);
  endtask

  task automatic tick();
    int i;
    @(posedge clk);
    #1;
    cyc++;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        total++;
        assert (obs() === sb[i].v) else begin
          bad++;
          $error("FAIL %s: observed=%h expected=%h (prm,bin,chg,dlt,err,cnt)", sb[i].tag, obs(), sb[i].v);
        end
        sb.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Drive one new Gray value; its compared result appears three edges later.
  task automatic step(input logic [3:0] g, input string tag, input logic [3:0] bin,
                      input logic [3:0] dlt, input logic err, input logic [7:0] cnt,
                      input logic clr_at_eval);
    gray_in = g;
    push(3, tag, 1'b1, bin, 1'b1, dlt, err, cnt);
    push(4, {tag, "_hold"}, 1'b1, bin, 1'b0, 4'd0, err, cnt);
    ticks(2);
    clr_err = clr_at_eval;
    tick();
    clr_err = 1'b0;
    tick();
  endtask

  initial begin
    logic [3:0] g;
    rst_n   = 1'b0;
    gray_in = 4'b0101;
    clr_err = 1'b0;
    #12;
    total++;
    assert (obs_all() === 23'd0) else begin
      bad++;
      $error("FAIL reset_hold: observed=%h expected=%h", obs_all(), 23'd0);
    end

    @(negedge clk);
    rst_n = 1'b1;
    push(1, "warm1", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0);
    push(2, "warm2", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0);
    push(3, "primed", 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 8'd0);
    push(4, "first_cmp", 1'b1, 4'd6, 1'b0, 4'd0, 1'b0, 8'd0);
    ticks(5);

    step(4'b0100, "b7", 4'd7, 4'd1, 1'b0, 8'd0, 1'b0);
    step(4'b0000, "b0", 4'd0, 4'd9, 1'b0, 8'd0, 1'b0);

    gray_in = 4'b0001;
    push(3, "inc01", 1'b1, 4'd1, 1'b1, 4'd1, 1'b0, 8'd0);
    push(4, "inc01_hold", 1'b1, 4'd1, 1'b0, 4'd0, 1'b0, 8'd0);
    ticks(2);
    total++;
    assert (gray_sync === 4'b0001) else begin
      bad++;
      $error("FAIL gray_sync_lat: observed=%b expected=%b", gray_sync, 4'b0001);
    end
    ticks(2);

    step(4'b0000, "back_to0", 4'd0, 4'd15, 1'b0, 8'd0, 1'b0);
    step(4'b1000, "back_to15", 4'd15, 4'd15, 1'b0, 8'd0, 1'b0);
    step(4'b0000, "wrap", 4'd0, 4'd1, 1'b0, 8'd0, 1'b0);
    step(4'b0001, "fwd1", 4'd1, 4'd1, 1'b0, 8'd0, 1'b0);
    step(4'b0000, "rev", 4'd0, 4'd15, 1'b0, 8'd0, 1'b0);

    step(4'b0011, "illegal1", 4'd2, 4'd2, 1'b1, 8'd1, 1'b0);
    step(4'b0000, "illegal2", 4'd0, 4'd14, 1'b1, 8'd2, 1'b0);

    clr_err = 1'b1;
    push(1, "clr", 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0);
    tick();
    clr_err = 1'b0;
    ticks(2);

    step(4'b0011, "illegal3", 4'd2, 4'd2, 1'b1, 8'd1, 1'b0);
    step(4'b0000, "clr_vs_set", 4'd0, 4'd14, 1'b1, 8'd1, 1'b1);

    for (int i = 0; i < 300; i++) begin
      int c;
      c = (i + 2 > 255) ? 255 : i + 2;
      gray_in = (i % 2 == 0) ? 4'b0011 : 4'b0000;
      push(3, $sformatf("sat%0d", i), 1'b1, (i % 2 == 0) ? 4'd2 : 4'd0, 1'b1,
           (i % 2 == 0) ? 4'd2 : 4'd14, 1'b1, 8'(c));
      ticks(4);
    end

    for (int b = 1; b <= 8; b++) begin
      g = 4'(b ^ (b >> 1));
      gray_in = g;
      if (b <= 5) push(3, $sformatf("stream%0d", b), 1'b1, 4'(b), 1'b1, 4'd1, 1'b1, 8'd255);
      tick();
    end
    #2;
    rst_n   = 1'b0;
    gray_in = 4'b1101;
    #1;
    total++;
    assert (obs_all() === 23'd0) else begin
      bad++;
      $error("FAIL reset_mid: observed=%h expected=%h", obs_all(), 23'd0);
    end
    ticks(2);

    @(negedge clk);
    rst_n = 1'b1;
    push(1, "rewarm1", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0);
    push(2, "rewarm2", 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 8'd0);
    push(3, "reprimed", 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 8'd0);
    push(4, "recmp1", 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 8'd0);
    push(5, "recmp2", 1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 8'd0);
    ticks(6);

    total++;
    assert (sb.size() === 0) else begin
      bad++;
      $error("FAIL scoreboard_drain: observed=%0d expected=%0d", sb.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
